// File: rtl/uart_axil_bridge_if.sv
// AXI_LITE: 32-bit AXI-Lite bus between the UART bridge (Master) and the UART Lite slave (Slave).
interface AXI_LITE;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic [ADDR_W-1:0]   aw_addr;
  logic                aw_valid;
  logic                aw_ready;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_valid;
  logic                w_ready;
  logic [1:0]          b_resp;
  logic                b_valid;
  logic                b_ready;
  logic [ADDR_W-1:0]   ar_addr;
  logic                ar_valid;
  logic                ar_ready;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp;
  logic                r_valid;
  logic                r_ready;

  modport Master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );

  modport Slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );
endinterface

// File: rtl/uart_axil_bridge.sv
// uart_axil_bridge: AXI-Lite master moving a byte stream into/out of a UART Lite by polling STAT.
// Optional UART_AXIL_FIFO_RESET_EN: after reset, write CTRL=0x3 to clear the UART FIFOs first.
module uart_axil_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned POLL_GAP  = 4
) (
  input  logic       clk,
  input  logic       rst,
  AXI_LITE.Master    axi,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       err
);
  localparam int unsigned GAP_W = (POLL_GAP > 2) ? $clog2(POLL_GAP) : 1;
  localparam logic [31:0] RX_ADDR   = BASE_ADDR;
  localparam logic [31:0] TX_ADDR   = BASE_ADDR + 32'h4;
  localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'h8;

  typedef enum logic [2:0] {
    ST_INIT, ST_POLL_AR, ST_POLL_R, ST_TX_AW_W, ST_TX_B, ST_RX_AR, ST_RX_R, ST_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic               aw_valid_q, aw_valid_d, w_valid_q, w_valid_d, b_ready_q, b_ready_d;
  logic               ar_valid_q, ar_valid_d, r_ready_q, r_ready_d;
  logic [31:0]        aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d, w_data_q, w_data_d;
  logic [3:0]         w_strb_q, w_strb_d;
  logic [7:0]         hold_q, hold_d, rx_data_q, rx_data_d;
  logic               hold_full_q, hold_full_d, tx_ready_q, tx_ready_d;
  logic               rx_valid_q, rx_valid_d, err_q, err_d, last_tx_q, last_tx_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               can_tx, can_rx, go_poll;
`ifdef UART_AXIL_FIFO_RESET_EN
  logic               init_sent_q, init_sent_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      aw_addr_q   <= '0;
      ar_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_ready_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      last_tx_q   <= 1'b0;
      gap_cnt_q   <= '0;
`ifdef UART_AXIL_FIFO_RESET_EN
      init_sent_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      aw_valid_q  <= aw_valid_d;
      w_valid_q   <= w_valid_d;
      b_ready_q   <= b_ready_d;
      ar_valid_q  <= ar_valid_d;
      r_ready_q   <= r_ready_d;
      aw_addr_q   <= aw_addr_d;
      ar_addr_q   <= ar_addr_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_ready_q  <= tx_ready_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      err_q       <= err_d;
      last_tx_q   <= last_tx_d;
      gap_cnt_q   <= gap_cnt_d;
`ifdef UART_AXIL_FIFO_RESET_EN
      init_sent_q <= init_sent_d;
`endif
    end
  end

  always_comb begin
    // Each channel valid/ready falls on its own handshake; states only raise them.
    state_d     = state_q;
    aw_valid_d  = aw_valid_q && !axi.aw_ready;
    w_valid_d   = w_valid_q && !axi.w_ready;
    b_ready_d   = b_ready_q && !axi.b_valid;
    ar_valid_d  = ar_valid_q && !axi.ar_ready;
    r_ready_d   = r_ready_q && !axi.r_valid;
    aw_addr_d   = aw_addr_q;
    ar_addr_d   = ar_addr_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    err_d       = err_q;
    last_tx_d   = last_tx_q;
    gap_cnt_d   = gap_cnt_q;
    can_tx      = 1'b0;
    can_rx      = 1'b0;
    go_poll     = 1'b0;
`ifdef UART_AXIL_FIFO_RESET_EN
    init_sent_d = init_sent_q;
`endif

    if (tx_valid && tx_ready_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      ST_INIT: begin
`ifdef UART_AXIL_FIFO_RESET_EN
        if (!init_sent_q) begin
          init_sent_d = 1'b1;
          aw_valid_d  = 1'b1;
          w_valid_d   = 1'b1;
          aw_addr_d   = BASE_ADDR + 32'hC;
          w_data_d    = 32'h3;
          w_strb_d    = 4'hF;
        end else if (b_ready_q && axi.b_valid) begin
          if (axi.b_resp != 2'b00) err_d = 1'b1;
          go_poll = 1'b1;
        end else if (!aw_valid_d && !w_valid_d) begin
          b_ready_d = 1'b1;
        end
`else
        go_poll = 1'b1;
`endif
      end
      ST_POLL_AR: begin
        if (!ar_valid_d) begin
          state_d   = ST_POLL_R;
          r_ready_d = 1'b1;
        end
      end
      ST_POLL_R: begin
        if (r_ready_q && axi.r_valid) begin
          // A failed STAT read counts as "nothing to do".
          if (axi.r_resp != 2'b00) begin
            err_d = 1'b1;
          end else begin
            can_tx = hold_full_q && !axi.r_data[3];
            can_rx = axi.r_data[0] && !rx_valid_q;
          end
          if (can_tx && (!can_rx || !last_tx_q)) begin
            state_d    = ST_TX_AW_W;
            last_tx_d  = 1'b1;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_addr_d  = TX_ADDR;
            w_data_d   = {24'h0, hold_q};
            w_strb_d   = 4'h1;
          end else if (can_rx) begin
            state_d    = ST_RX_AR;
            last_tx_d  = 1'b0;
            ar_valid_d = 1'b1;
            ar_addr_d  = RX_ADDR;
          end else if (POLL_GAP == 0) begin
            go_poll = 1'b1;
          end else begin
            state_d   = ST_WAIT;
            gap_cnt_d = GAP_W'(POLL_GAP - 1);
          end
        end
      end
      ST_TX_AW_W: begin
        if (!aw_valid_d && !w_valid_d) begin
          state_d   = ST_TX_B;
          b_ready_d = 1'b1;
        end
      end
      ST_TX_B: begin
        if (b_ready_q && axi.b_valid) begin
          hold_full_d = 1'b0;
          if (axi.b_resp != 2'b00) err_d = 1'b1;
          go_poll = 1'b1;
        end
      end
      ST_RX_AR: begin
        if (!ar_valid_d) begin
          state_d   = ST_RX_R;
          r_ready_d = 1'b1;
        end
      end
      ST_RX_R: begin
        if (r_ready_q && axi.r_valid) begin
          rx_data_d  = axi.r_data[7:0];
          rx_valid_d = 1'b1;
          if (axi.r_resp != 2'b00) err_d = 1'b1;
          go_poll = 1'b1;
        end
      end
      ST_WAIT: begin
        if (gap_cnt_q == '0) go_poll = 1'b1;
        else gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      default: state_d = ST_INIT;
    endcase

    if (go_poll) begin
      state_d    = ST_POLL_AR;
      ar_valid_d = 1'b1;
      ar_addr_d  = STAT_ADDR;
    end

    tx_ready_d = !hold_full_d && (state_d != ST_INIT);
  end

  assign axi.aw_addr  = aw_addr_q;
  assign axi.aw_valid = aw_valid_q;
  assign axi.w_data   = w_data_q;
  assign axi.w_strb   = w_strb_q;
  assign axi.w_valid  = w_valid_q;
  assign axi.b_ready  = b_ready_q;
  assign axi.ar_addr  = ar_addr_q;
  assign axi.ar_valid = ar_valid_q;
  assign axi.r_ready  = r_ready_q;
  assign tx_ready     = tx_ready_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign err          = err_q;
endmodule

// File: tb/tb_uart_axil_bridge.sv
// tb_uart_axil_bridge: directed self-checking bench with a small UART Lite slave model.
module tb_uart_axil_bridge;
  localparam logic [7:0] OP_T = 8'h54;
  localparam logic [7:0] OP_R = 8'h52;

  logic       clk, rst;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ready, err;

  AXI_LITE axi();

  uart_axil_bridge #(.BASE_ADDR(32'h0), .POLL_GAP(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .axi      (axi),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp, n_err;
  int cyc, n_stat, n_rx, n_writes, n_bad, stat_t, stat_t_prev;
  logic [7:0]  stat_val, rx_byte;
  logic [1:0]  bresp_cfg;
  logic        aw_got, w_got;
  logic [31:0] waddr, wdata;
  logic [3:0]  wstrb;
  logic [7:0]  ops[$];

  always @(posedge clk) cyc <= cyc + 1;

  // UART Lite slave model: zero-wait AR, one-cycle read data, B after both AW and W.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      axi.r_valid <= 1'b0;
      axi.r_data  <= '0;
      axi.r_resp  <= 2'b00;
      axi.b_valid <= 1'b0;
      axi.b_resp  <= 2'b00;
      aw_got      <= 1'b0;
      w_got       <= 1'b0;
    end else begin
      if (axi.ar_valid && axi.ar_ready) begin
        axi.r_valid <= 1'b1;
        axi.r_resp  <= 2'b00;
        if (axi.ar_addr == 32'h8) begin
          axi.r_data  <= {24'h0, stat_val};
          n_stat      <= n_stat + 1;
          stat_t_prev <= stat_t;
          stat_t      <= cyc;
        end else if (axi.ar_addr == 32'h0) begin
          axi.r_data <= {24'h0, rx_byte};
          n_rx       <= n_rx + 1;
          ops.push_back(OP_R);
        end else begin
          n_bad <= n_bad + 1;
        end
      end else if (axi.r_valid && axi.r_ready) begin
        axi.r_valid <= 1'b0;
      end
      if (axi.aw_valid && axi.aw_ready) begin
        aw_got <= 1'b1;
        waddr  <= axi.aw_addr;
      end
      if (axi.w_valid && axi.w_ready) begin
        w_got <= 1'b1;
        wdata <= axi.w_data;
        wstrb <= axi.w_strb;
      end
      if (aw_got && w_got) begin
        aw_got      <= 1'b0;
        w_got       <= 1'b0;
        axi.b_valid <= 1'b1;
        axi.b_resp  <= bresp_cfg;
        n_writes    <= n_writes + 1;
        ops.push_back(OP_T);
      end else if (axi.b_valid && axi.b_ready) begin
        axi.b_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    tx_data  = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    chk("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_writes(input int target);
    for (int i = 0; i < 300 && n_writes < target; i++) @(negedge clk);
  endtask

  task automatic wait_tx_ready();
    for (int i = 0; i < 300 && !tx_ready; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
  endtask

  int s0, w0, r0, o0;

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
    stat_val = 8'h00; rx_byte = 8'h00; bresp_cfg = 2'b00;
    axi.aw_ready = 1'b1; axi.w_ready = 1'b1; axi.ar_ready = 1'b1;
    wait_cyc(3);

    chk("rst_axi_valids", 32'({axi.aw_valid, axi.w_valid, axi.ar_valid, axi.r_ready, axi.b_ready}), 32'd0);
    chk("rst_streams", 32'({tx_ready, rx_valid, rx_data, err}), 32'd0);
    chk("rst_addr_data", axi.aw_addr | axi.ar_addr | axi.w_data, 32'd0);

    rst = 1'b0;
    @(negedge clk);
    chk("tx_ready_first_cycle", 32'(tx_ready), 32'd1);
    chk("first_ar_valid", 32'(axi.ar_valid), 32'd1);
    chk("first_ar_addr", axi.ar_addr, 32'h8);

    // Idle: STAT polls only, POLL_GAP+2 cycles apart.
    s0 = n_stat;
    for (int i = 0; i < 200 && n_stat < s0 + 4; i++) @(negedge clk);
    chk("idle_poll_count", 32'(n_stat >= s0 + 4), 32'd1);
    chk("idle_poll_spacing", 32'(stat_t - stat_t_prev), 32'd6);
    chk("idle_no_writes", 32'(n_writes), 32'd0);
    chk("idle_no_rx_reads", 32'(n_rx), 32'd0);

    // Single TX with W held off: AW and W drop independently.
    stat_val = 8'h04; axi.w_ready = 1'b0; w0 = n_writes;
    send(8'h41);
    for (int i = 0; i < 100 && !axi.w_valid; i++) @(negedge clk);
    @(negedge clk);
    chk("tx_aw_done_w_pending", 32'({axi.aw_valid, axi.w_valid}), 32'b01);
    axi.w_ready = 1'b1;
    wait_writes(w0 + 1);
    chk("tx_write_count", 32'(n_writes - w0), 32'd1);
    chk("tx_waddr", waddr, 32'h4);
    chk("tx_wdata", wdata, 32'h41);
    chk("tx_wstrb", 32'(wstrb), 32'h1);
    wait_tx_ready();
    chk("tx_ready_back", 32'(tx_ready), 32'd1);

    // TX FIFO full: byte stays held until STAT clears bit 3.
    stat_val = 8'h08; w0 = n_writes;
    send(8'h42);
    s0 = n_stat;
    for (int i = 0; i < 200 && n_stat < s0 + 3; i++) @(negedge clk);
    chk("full_polls_seen", 32'(n_stat - s0), 32'd3);
    chk("full_no_write", 32'(n_writes - w0), 32'd0);
    chk("full_tx_ready_low", 32'(tx_ready), 32'd0);
    stat_val = 8'h04;
    wait_writes(w0 + 1);
    chk("full_wdata", wdata, 32'h42);
    wait_cyc(40);
    chk("full_exactly_one", 32'(n_writes - w0), 32'd1);

    // RX with consumer stalled: one read, held until rx_ready.
    stat_val = 8'h01; rx_byte = 8'h5A; rx_ready = 1'b0;
    for (int i = 0; i < 200 && !rx_valid; i++) @(negedge clk);
    chk("rx_valid_set", 32'(rx_valid), 32'd1);
    chk("rx_data", 32'(rx_data), 32'h5A);
    r0 = n_rx;
    wait_cyc(40);
    chk("rx_no_extra_read", 32'(n_rx - r0), 32'd0);
    chk("rx_valid_held", 32'(rx_valid), 32'd1);
    stat_val = 8'h00;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("rx_valid_cleared", 32'(rx_valid), 32'd0);
    wait_cyc(20);
    chk("rx_total_reads", 32'(n_rx - r0), 32'd0);

    // Round-robin: both sides pending, TX wins first after reset.
    do_reset();
    stat_val = 8'h05; rx_byte = 8'h11; rx_ready = 1'b1; o0 = ops.size();
    send(8'h33);
    send(8'h33);
    for (int i = 0; i < 300 && ops.size() < o0 + 3; i++) @(negedge clk);
    chk("rr_first_tx", 32'(ops[o0]), 32'(OP_T));
    chk("rr_second_rx", 32'(ops[o0 + 1]), 32'(OP_R));
    chk("rr_third_tx", 32'(ops[o0 + 2]), 32'(OP_T));
    stat_val = 8'h00;
    wait_cyc(20);
    rx_ready = 1'b0;

    // Error response on a TX write: sticky err, byte still consumed.
    stat_val = 8'h04; bresp_cfg = 2'b10; w0 = n_writes;
    send(8'h77);
    wait_writes(w0 + 1);
    wait_tx_ready();
    chk("bresp_err_set", 32'(err), 32'd1);
    chk("bresp_hold_cleared", 32'(tx_ready), 32'd1);
    bresp_cfg = 2'b00;
    send(8'h78);
    wait_writes(w0 + 2);
    wait_cyc(5);
    chk("err_sticky", 32'(err), 32'd1);
    do_reset();
    chk("err_cleared_by_reset", 32'(err), 32'd0);

    // Asynchronous reset while AW/W are stalled.
    stat_val = 8'h04; axi.aw_ready = 1'b0; axi.w_ready = 1'b0; w0 = n_writes;
    send(8'h99);
    for (int i = 0; i < 200 && !axi.aw_valid; i++) @(negedge clk);
    chk("stall_aw_w_up", 32'({axi.aw_valid, axi.w_valid}), 32'b11);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_drop", 32'({axi.aw_valid, axi.w_valid}), 32'b00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; axi.aw_ready = 1'b1; axi.w_ready = 1'b1; stat_val = 8'h00;
    s0 = n_stat;
    for (int i = 0; i < 100 && n_stat == s0; i++) @(negedge clk);
    chk("post_rst_poll", 32'(n_stat - s0), 32'd1);
    chk("post_rst_tx_ready", 32'(tx_ready), 32'd1);
    wait_cyc(20);
    chk("post_rst_no_write", 32'(n_writes - w0), 32'd0);
    chk("no_bad_addresses", 32'(n_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
